// File: rtl/wb_write_ctrl.sv
// Writeback write-port controller: ALU/load arbitration, load FIFO, r0 suppression, pending scoreboard.
// Optional WB_LD_BYPASS_EN: a load may skip an empty FIFO when the ALU is idle.
module wb_write_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_LIM = 3
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Alu_valid,
    input  logic [4:0]               Alu_rd,
    input  logic [31:0]              Alu_data,
    output logic                     Alu_ready,
    input  logic                     Ld_valid,
    input  logic [4:0]               Ld_rd,
    input  logic [31:0]              Ld_data,
    output logic                     Ld_ready,
    output logic [31:0]              D,
    output logic [31:0]              En,
    output logic [31:0]              Pending,
    output logic [$clog2(DEPTH):0]   Ld_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = (STARVE_LIM < 2) ? 1 : $clog2(STARVE_LIM + 1);

    logic [4:0]       mem_rd_q   [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [31:0]      en_q, en_d;
    logic [31:0]      d_q, d_d;

    logic        fifo_empty;
    logic        fifo_full;
    logic        force_drain;
    logic        pop;
    logic        push;
    logic        bypass;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [31:0] issue_data;

    always_comb begin
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == CW'(DEPTH));
        force_drain = !fifo_empty && ((starve_q == SW'(STARVE_LIM)) || fifo_full);
        Alu_ready   = !force_drain;
        Ld_ready    = !fifo_full;

        pop        = 1'b0;
        bypass     = 1'b0;
        issue      = 1'b0;
        issue_rd   = '0;
        issue_data = '0;
        starve_d   = starve_q;

        if (force_drain) begin
            pop = 1'b1;
        end else if (Alu_valid) begin
            issue      = 1'b1;
            issue_rd   = Alu_rd;
            issue_data = Alu_data;
            if (!fifo_empty) begin
                starve_d = starve_q + SW'(1);
            end
        end else if (!fifo_empty) begin
            pop = 1'b1;
        end
`ifdef WB_LD_BYPASS_EN
        else if (Ld_valid) begin
            bypass     = 1'b1;
            issue      = 1'b1;
            issue_rd   = Ld_rd;
            issue_data = Ld_data;
        end
`endif

        if (pop) begin
            issue      = 1'b1;
            issue_rd   = mem_rd_q[rd_ptr_q];
            issue_data = mem_data_q[rd_ptr_q];
        end
        if (pop || fifo_empty) begin
            starve_d = '0;
        end

        // Full blocks the push even when this cycle also pops.
        push = Ld_valid && Ld_ready && !bypass;
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

        live_d = live_q;
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            live_d[wr_ptr_q] = 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (issue && (issue_rd != '0)) begin
            en_d = 32'(1) << issue_rd;
            d_d  = issue_data;
        end else begin
            en_d = '0;
            d_d  = d_q;
        end
    end

    always_comb begin
        Pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (mem_rd_q[i] != '0)) begin
                Pending = Pending | (32'(1) << mem_rd_q[i]);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            en_q     <= '0;
            d_q      <= '0;
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            en_q     <= en_d;
            d_q      <= d_d;
        end
    end

    // Storage needs no reset: live_q gates every read of it.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_rd_q[wr_ptr_q]   <= Ld_rd;
            mem_data_q[wr_ptr_q] <= Ld_data;
        end
    end

    assign D        = d_q;
    assign En       = en_q;
    assign Ld_count = count_q;

endmodule

// File: tb/tb_wb_write_ctrl.sv
// Bench for wb_write_ctrl: queue-based reference model checked every cycle, plus directed literal checks.
module tb_wb_write_ctrl;

    localparam int DEPTH = 4;
    localparam int LIM   = 3;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Alu_valid, Ld_valid, Alu_ready, Ld_ready;
    logic [4:0]  Alu_rd, Ld_rd;
    logic [31:0] Alu_data, Ld_data, D, En, Pending;
    logic [2:0]  Ld_count;

    logic        b_alu_valid, b_ld_valid, b_alu_ready, b_ld_ready;
    logic [4:0]  b_alu_rd, b_ld_rd;
    logic [31:0] b_alu_data, b_ld_data, b_d, b_en, b_pending;
    logic [2:0]  b_ld_count;

    always #5 Clk = ~Clk;

    wb_write_ctrl #(.DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .Clk(Clk), .Rst(Rst),
        .Alu_valid(Alu_valid), .Alu_rd(Alu_rd), .Alu_data(Alu_data), .Alu_ready(Alu_ready),
        .Ld_valid(Ld_valid), .Ld_rd(Ld_rd), .Ld_data(Ld_data), .Ld_ready(Ld_ready),
        .D(D), .En(En), .Pending(Pending), .Ld_count(Ld_count)
    );

    wb_write_ctrl #(.DEPTH(DEPTH), .STARVE_LIM(15)) dut15 (
        .Clk(Clk), .Rst(Rst),
        .Alu_valid(b_alu_valid), .Alu_rd(b_alu_rd), .Alu_data(b_alu_data), .Alu_ready(b_alu_ready),
        .Ld_valid(b_ld_valid), .Ld_rd(b_ld_rd), .Ld_data(b_ld_data), .Ld_ready(b_ld_ready),
        .D(b_d), .En(b_en), .Pending(b_pending), .Ld_count(b_ld_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of pending loads plus a starvation count.
    typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    int          starve = 0;
    logic [31:0] m_en = '0, m_d = '0;
    bit          model_on = 1'b0;

    function automatic logic [31:0] dec(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : (32'd1 << r);
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        foreach (mq[i]) p |= dec(mq[i].rd);
        return p;
    endfunction

    function automatic bit m_force();
        return (mq.size() != 0) && ((starve == LIM) || (mq.size() == DEPTH));
    endfunction

    always @(posedge Clk) begin : model
        bit   had, frc, take_head, byp, iss, can_push;
        ent_t w;
        if (Rst) begin
            mq.delete();
            starve   = 0;
            m_en     = '0;
            m_d      = '0;
            model_on = 1'b1;
        end else begin
            had       = (mq.size() != 0);
            frc       = m_force();
            can_push  = Ld_valid && (mq.size() < DEPTH);
            take_head = 1'b0;
            byp       = 1'b0;
            iss       = 1'b0;
            w         = '0;
            if (frc) take_head = 1'b1;
            else if (Alu_valid) begin
                iss = 1'b1; w.rd = Alu_rd; w.data = Alu_data;
                if (had) starve++;
            end
            else if (had) take_head = 1'b1;
`ifdef WB_LD_BYPASS_EN
            else if (Ld_valid) begin
                iss = 1'b1; byp = 1'b1; w.rd = Ld_rd; w.data = Ld_data;
            end
`endif
            if (take_head) begin w = mq.pop_front(); iss = 1'b1; end
            if (take_head || !had) starve = 0;
            if (can_push && !byp) begin
                ent_t n;
                n.rd = Ld_rd; n.data = Ld_data;
                mq.push_back(n);
            end
            m_en = iss ? dec(w.rd) : 32'd0;
            if (iss && (w.rd != 5'd0)) m_d = w.data;
        end
    end

    always @(negedge Clk) begin
        if (model_on) begin
            check("en", En, m_en);
            check("d", D, m_d);
            check("ld_count", {29'd0, Ld_count}, mq.size());
            check("pending", Pending, m_pending());
            if (!Rst) begin
                check("alu_ready", {31'd0, Alu_ready}, {31'd0, !m_force()});
                check("ld_ready", {31'd0, Ld_ready}, {31'd0, mq.size() < DEPTH});
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle0();
        Alu_valid = 0; Alu_rd = 0; Alu_data = 0;
        Ld_valid = 0; Ld_rd = 0; Ld_data = 0;
    endtask

    task automatic rand0();
        Alu_valid = 1'($urandom); Alu_rd = 5'($urandom); Alu_data = $urandom;
        Ld_valid = 1'($urandom); Ld_rd = 5'($urandom); Ld_data = $urandom;
    endtask

    int alu_pct[6] = '{80, 30, 95, 50, 10, 60};
    int ld_pct[6]  = '{50, 70, 40, 90, 30, 20};

    initial begin
        b_alu_valid = 0; b_alu_rd = 0; b_alu_data = 0;
        b_ld_valid = 0; b_ld_rd = 0; b_ld_data = 0;

        // Reset held for two edges with random inputs
        Rst = 1'b1; rand0();
        step(); rand0();
        step(); Rst = 1'b0; idle0();
        @(negedge Clk);
        check("rst_en", En, 32'd0);
        check("rst_d", D, 32'd0);
        check("rst_count", {29'd0, Ld_count}, 32'd0);
        check("rst_pending", Pending, 32'd0);
        check("rst_ld_ready", {31'd0, Ld_ready}, 32'd1);

        // ALU write to r5
        Alu_valid = 1; Alu_rd = 5; Alu_data = 32'hDEADBEEF;
        @(negedge Clk); check("t2_alu_ready", {31'd0, Alu_ready}, 32'd1);
        step(); idle0();
        @(negedge Clk); check("t2_en", En, 32'h0000_0020); check("t2_d", D, 32'hDEADBEEF);
        step();
        @(negedge Clk); check("t2_en_clear", En, 32'd0);

        // ALU write to r0 is accepted but never enables
        Alu_valid = 1; Alu_rd = 0; Alu_data = 32'h12345678;
        @(negedge Clk); check("t3_alu_ready", {31'd0, Alu_ready}, 32'd1);
        step(); idle0();
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk); check("t3_en", En, 32'd0); check("t3_d_hold", D, 32'hDEADBEEF);
            step();
        end

        // Load to r7 under continuous ALU traffic: starvation forces it through
        Alu_valid = 1; Alu_rd = 3; Alu_data = $urandom;
        Ld_valid = 1; Ld_rd = 7; Ld_data = 32'hCAFE0007;
        @(negedge Clk); check("t4_ld_ready", {31'd0, Ld_ready}, 32'd1);
        step(); Ld_valid = 0; Alu_data = $urandom;
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clk);
            check("t4_alu_ready_win", {31'd0, Alu_ready}, 32'd1);
            check("t4_pend7", Pending & 32'h80, 32'h80);
            step(); Alu_data = $urandom;
        end
        @(negedge Clk);
        check("t4_alu_ready_forced", {31'd0, Alu_ready}, 32'd0);
        check("t4_pend7_before_pop", Pending & 32'h80, 32'h80);
        step();
        @(negedge Clk);
        check("t4_en", En, 32'h0000_0080);
        check("t4_d", D, 32'hCAFE0007);
        check("t4_pend7_clear", Pending & 32'h80, 32'd0);
        step(); idle0();

        // STARVE_LIM=15 instance: fill to full, forced drain by fullness, order kept
        b_alu_valid = 1; b_alu_rd = 20; b_alu_data = 32'hA1A1A1A1;
        for (int k = 1; k <= 4; k++) begin
            b_ld_valid = 1; b_ld_rd = 5'(k); b_ld_data = 32'h1000 + k;
            step();
        end
        b_ld_rd = 5; b_ld_data = 32'h1005;
        @(negedge Clk);
        check("t5_count_full", {29'd0, b_ld_count}, 32'd4);
        check("t5_ld_ready_full", {31'd0, b_ld_ready}, 32'd0);
        check("t5_alu_ready_full", {31'd0, b_alu_ready}, 32'd0);
        step();
        @(negedge Clk);
        check("t5_first_en", b_en, 32'h2);
        check("t5_first_d", b_d, 32'h1001);
        check("t5_count3", {29'd0, b_ld_count}, 32'd3);
        check("t5_ld_ready3", {31'd0, b_ld_ready}, 32'd1);
        step(); b_alu_valid = 0; b_ld_valid = 0;
        @(negedge Clk);
        check("t5_count_refill", {29'd0, b_ld_count}, 32'd4);
        check("t5_alu_en", b_en, 32'h0010_0000);
        step();
        for (int k = 2; k <= 5; k++) begin
            @(negedge Clk);
            check("t5_order_en", b_en, 32'd1 << k);
            check("t5_order_d", b_d, 32'h1000 + k);
            step();
        end
        @(negedge Clk); check("t5_drained", {29'd0, b_ld_count}, 32'd0);

        // Two queued loads discarded by reset
        Alu_valid = 1; Alu_rd = 2; Alu_data = 32'h0BADF00D;
        Ld_valid = 1; Ld_rd = 9; Ld_data = 32'h99999999;
        step(); Ld_rd = 10; Ld_data = 32'hAAAAAAAA;
        @(negedge Clk); check("t6_pend9", Pending & 32'h200, 32'h200);
        step(); Ld_valid = 0; Rst = 1;
        step(); Rst = 0; idle0();
        @(negedge Clk);
        check("t6_pending", Pending, 32'd0);
        check("t6_count", {29'd0, Ld_count}, 32'd0);
        check("t6_en", En, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge Clk); check("t6_no_r9_r10", En & 32'h600, 32'd0);
        end

        // Randomized traffic, occasional reset
        for (int c = 0; c < 3000; c++) begin
            step();
            Rst       = ($urandom_range(0, 199) == 0);
            Alu_valid = ($urandom_range(0, 99) < alu_pct[(c / 500) % 6]);
            Ld_valid  = ($urandom_range(0, 99) < ld_pct[(c / 500) % 6]);
            Alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            Ld_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            Alu_data  = $urandom;
            Ld_data   = $urandom;
        end
        step(); idle0(); Rst = 0;
        @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
